it2_fuzzifier: RTL

Interval type-2 fuzzifier: samples one 8-bit crisp input and produces the upper and lower membership grades of three triangular fuzzy sets. It sits at the front of the fuzzy processing chain and is the inverse end of the type-reduction/defuzzification stage. Its six FOU outputs drive the rule/inference stage and, from there, the defuzzifier. The memberships are computed serially through one shared restoring divider and published together with a one-cycle `pronto` strobe.

---
 rtl/it2_fuzzifier_if.sv | 27 ++
 rtl/it2_fuzzifier.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/it2_fuzzifier_if.sv
// it2_fuzzifier_if: sample/result bundle of the interval type-2 fuzzifier.
//   entrada, EN_entrada : crisp sample and start request (master -> slave)
//   FOU_i_UP/FOU_i_LOW  : registered upper/lower memberships (slave -> master)
//   ocupado, pronto     : busy flag and one-cycle result strobe (slave -> master)
// Clock and reset are not part of the bundle; they stay scalar ports.
interface it2_fuzzifier_if;
    logic [7:0] entrada;
    logic       EN_entrada;
    logic [7:0] FOU_1_UP, FOU_2_UP, FOU_3_UP;
    logic [7:0] FOU_1_LOW, FOU_2_LOW, FOU_3_LOW;
    logic       ocupado;
    logic       pronto;

    modport master (
        output entrada, EN_entrada,
        input  FOU_1_UP, FOU_2_UP, FOU_3_UP,
        input  FOU_1_LOW, FOU_2_LOW, FOU_3_LOW,
        input  ocupado, pronto
    );

    modport slave (
        input  entrada, EN_entrada,
        output FOU_1_UP, FOU_2_UP, FOU_3_UP,
        output FOU_1_LOW, FOU_2_LOW, FOU_3_LOW,
        output ocupado, pronto
    );
endinterface

// File: rtl/it2_fuzzifier.sv
// it2_fuzzifier: interval type-2 fuzzifier for three triangular sets.
// Latches one 8-bit crisp sample and computes the upper/lower membership
// grades serially through one shared 8-iteration restoring divider
// (1 setup cycle + 8 divide cycles per membership). All outputs are
// published together with a one-cycle pronto strobe.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : it2_fuzzifier_if.slave (entrada, EN_entrada, FOU_*, ocupado, pronto)
// Build option:
//   FUZZ_LOWER_MF_EN defined   -> 6 memberships (upper+lower), latency 54
//   FUZZ_LOWER_MF_EN undefined -> type-1 mode, 3 upper memberships, latency 27,
//                                 FOU_i_LOW mirrors FOU_i_UP
module it2_fuzzifier #(
    parameter logic [7:0] L1 = 8'd0,   C1 = 8'd64,  R1 = 8'd128,
    parameter logic [7:0] L2 = 8'd64,  C2 = 8'd128, R2 = 8'd192,
    parameter logic [7:0] L3 = 8'd128, C3 = 8'd192, R3 = 8'd255,
    parameter logic [7:0] DELTA = 8'd16,
    parameter logic [7:0] LOW_H = 8'd204
) (
    input  logic            clk,
    input  logic            rst,
    it2_fuzzifier_if.slave  bus
);

`ifdef FUZZ_LOWER_MF_EN
    localparam int NM = 6;
`else
    localparam int NM = 3;
`endif
    localparam logic [7:0] UP_H = 8'd255;

    typedef enum logic [1:0] {IDLE, SETUP, DIV} state_t;

    state_t              state, state_nx;
    logic [7:0]          x_q;
    logic [2:0]          idx;
    logic [2:0]          bit_cnt;
    logic [7:0]          rem, lo, den;
    logic [NM-1:0][7:0]  shadow;
    logic [2:0][7:0]     fou_up, fou_low;
    logic                pronto_q;

    // FSM control strobes
    logic start, div_last, last_mf, publish;

    // ---------------- triangle selection and region classification
    logic [1:0]  set_sel;
    logic        is_low;
    logic [7:0]  p_l, p_c, p_r, p_h;
    logic [7:0]  diff, den_c;
    logic [15:0] num_c;

    always_comb begin
`ifdef FUZZ_LOWER_MF_EN
        set_sel = idx[2:1];
        is_low  = idx[0];
`else
        set_sel = idx[1:0];
        is_low  = 1'b0;
`endif
        case (set_sel)
            2'd0:    begin p_l = L1; p_c = C1; p_r = R1; end
            2'd1:    begin p_l = L2; p_c = C2; p_r = R2; end
            default: begin p_l = L3; p_c = C3; p_r = R3; end
        endcase
        p_h = UP_H;
        if (is_low) begin
            // lower MF: same apex, base pulled in by DELTA on both sides
            p_l = p_l + DELTA;
            p_r = p_r - DELTA;
            p_h = LOW_H;
        end

        diff  = 8'd0;
        den_c = 8'd1;
        if (x_q > p_l && x_q <= p_c) begin
            diff  = x_q - p_l;
            den_c = p_c - p_l;
        end else if (x_q > p_c && x_q < p_r) begin
            diff  = p_r - x_q;
            den_c = p_r - p_c;
        end
        // diff <= den and H <= 255, so num < den*256: 8 quotient bits suffice
        num_c = {8'd0, p_h} * {8'd0, diff};
    end

    // ---------------- one restoring-divider step
    // rem holds the partial remainder (always < den); lo shifts out dividend
    // bits at the top while quotient bits shift in at the bottom.
    logic [8:0] trial, trial_sub;
    logic       q_bit;
    logic [7:0] rem_nx, quot;

    always_comb begin
        trial     = {rem, lo[7]};
        trial_sub = trial - {1'b0, den};
        q_bit     = (trial >= {1'b0, den});
        rem_nx    = q_bit ? trial_sub[7:0] : trial[7:0];
        quot      = {lo[6:0], q_bit};
    end

    // Last membership finishes on the publish edge, so substitute its
    // quotient directly instead of waiting for the shadow write.
    logic [NM-1:0][7:0] pub;

    always_comb begin
        pub        = shadow;
        pub[NM-1]  = quot;
    end

    // ---------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        div_last = 1'b0;
        last_mf  = (idx == 3'(NM - 1));
        publish  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.EN_entrada) begin
                    start    = 1'b1;
                    state_nx = SETUP;
                end
            end
            SETUP: state_nx = DIV;
            DIV: begin
                if (bit_cnt == 3'd7) begin
                    div_last = 1'b1;
                    if (last_mf) begin
                        publish  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = SETUP;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q      <= 8'd0;
            idx      <= 3'd0;
            bit_cnt  <= 3'd0;
            rem      <= 8'd0;
            lo       <= 8'd0;
            den      <= 8'd1;
            shadow   <= '0;
            fou_up   <= '0;
            fou_low  <= '0;
            pronto_q <= 1'b0;
        end else begin
            pronto_q <= publish;
            if (start) begin
                x_q <= bus.entrada;
                idx <= 3'd0;
            end
            if (state == SETUP) begin
                rem     <= num_c[15:8];
                lo      <= num_c[7:0];
                den     <= den_c;
                bit_cnt <= 3'd0;
            end
            if (state == DIV) begin
                rem     <= rem_nx;
                lo      <= quot;
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (div_last) begin
                for (int i = 0; i < NM; i++)
                    if (idx == 3'(i)) shadow[i] <= quot;
                if (!last_mf) idx <= idx + 3'd1;
            end
            if (publish) begin
`ifdef FUZZ_LOWER_MF_EN
                for (int s = 0; s < 3; s++) begin
                    fou_up[s]  <= pub[2*s];
                    fou_low[s] <= pub[2*s+1];
                end
`else
                for (int s = 0; s < 3; s++) begin
                    fou_up[s]  <= pub[s];
                    fou_low[s] <= pub[s];
                end
`endif
            end
        end
    end

    assign bus.FOU_1_UP  = fou_up[0];
    assign bus.FOU_2_UP  = fou_up[1];
    assign bus.FOU_3_UP  = fou_up[2];
    assign bus.FOU_1_LOW = fou_low[0];
    assign bus.FOU_2_LOW = fou_low[1];
    assign bus.FOU_3_LOW = fou_low[2];
    assign bus.ocupado   = (state != IDLE);
    assign bus.pronto    = pronto_q;

endmodule
